// File: rtl/knn_pkg.sv
// Shared FSM encoding and width helpers for the KNN vote selector and its sorted list.
package knn_pkg;

   typedef enum logic [1:0] {
      COLLECT,
      VOTE,
      DECIDE,
      RESOLVE
   } knn_state_e;

   function automatic int unsigned num_classes(input int unsigned type_w);
      return 2 ** type_w;
   endfunction

   function automatic int unsigned count_w(input int unsigned k);
      return $clog2(k + 1);
   endfunction

endpackage

// File: rtl/knn_sorted_list.sv
// K-entry ascending distance list: parallel compare, single-cycle insert/shift, flush.
module knn_sorted_list #(
   parameter int unsigned W      = 32,
   parameter int unsigned TYPE_W = 2,
   parameter int unsigned K      = 5
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         insert,
   input  logic [2*W-1:0]               distance,
   input  logic [TYPE_W-1:0]            data_type,
   output logic [K-1:0]                 ent_valid,
   output logic [K-1:0][2*W-1:0]        ent_dist,
   output logic [K-1:0][TYPE_W-1:0]     ent_cls
);

   logic [K-1:0]             keep;
   logic [K-1:0]             prev_keep;
   logic [K-1:0]             sh_valid;
   logic [K-1:0][2*W-1:0]    sh_dist;
   logic [K-1:0][TYPE_W-1:0] sh_cls;

   // A slot keeps its entry when it is valid and <= the newcomer (stable ties);
   // the first non-kept slot takes the newcomer, later slots take their predecessor.
   always_comb begin
      keep = '0;
      for (int unsigned i = 0; i < K; i++) begin
         keep[i] = ent_valid[i] && (ent_dist[i] <= distance);
      end
      prev_keep = (keep << 1) | K'(1);
      sh_valid  = ent_valid << 1;
      sh_dist   = ent_dist << (2 * W);
      sh_cls    = ent_cls << TYPE_W;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ent_valid <= '0;
         ent_dist  <= '0;
         ent_cls   <= '0;
      end else if (flush) begin
         ent_valid <= '0;
      end else if (insert) begin
         for (int unsigned i = 0; i < K; i++) begin
            if (!keep[i]) begin
               if (prev_keep[i]) begin
                  ent_valid[i] <= 1'b1;
                  ent_dist[i]  <= distance;
                  ent_cls[i]   <= data_type;
               end else begin
                  ent_valid[i] <= sh_valid[i];
                  ent_dist[i]  <= sh_dist[i];
                  ent_cls[i]   <= sh_cls[i];
               end
            end
         end
      end
   end

endmodule

// File: rtl/knn_vote_selector.sv
// KNN vote selector: keeps the K nearest samples, majority-votes their labels per input vector.
// Optional KNN_TIE_NEAREST_EN: break vote ties toward the class of the nearest tied entry.
module knn_vote_selector
   import knn_pkg::*;
#(
   parameter int unsigned W           = 32,
   parameter int unsigned TYPE_W      = 2,
   parameter int unsigned K           = 5,
   parameter int unsigned NUM_SAMPLES = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    dist_valid,
   input  logic [2*W-1:0]          distance,
   input  logic [TYPE_W-1:0]       data_type,
   output logic                    busy,
   output logic                    result_valid,
   output logic [TYPE_W-1:0]       result_class,
   output logic [count_w(K)-1:0]   result_votes,
   output logic [2*W-1:0]          nearest_distance,
   output logic                    overflow
);

   localparam int unsigned CW   = count_w(K);
   localparam int unsigned NCLS = num_classes(TYPE_W);
   localparam int unsigned IW   = (K > 1) ? $clog2(K) : 1;
   localparam int unsigned SW   = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;

   knn_state_e               state, state_n;
   logic [IW-1:0]            idx;
   logic [SW-1:0]            scnt;
   logic [NCLS-1:0][CW-1:0]  class_cnt;
   logic                     accept, last_idx, last_sample, emit, flush;
   logic [TYPE_W-1:0]        best_cls, res_cls;
   logic [CW-1:0]            best_cnt, res_votes;
   logic [K-1:0]             ent_valid;
   logic [K-1:0][2*W-1:0]    ent_dist;
   logic [K-1:0][TYPE_W-1:0] ent_cls;

   knn_sorted_list #(
      .W      (W),
      .TYPE_W (TYPE_W),
      .K      (K)
   ) u_list (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .insert    (accept),
      .distance  (distance),
      .data_type (data_type),
      .ent_valid (ent_valid),
      .ent_dist  (ent_dist),
      .ent_cls   (ent_cls)
   );

   always_comb begin
      busy        = (state != COLLECT);
      accept      = (state == COLLECT) && dist_valid && !clear;
      last_idx    = (idx == IW'(K - 1));
      last_sample = (scnt == SW'(NUM_SAMPLES - 1));
      // strict '>' keeps the lowest class index on equal counts
      best_cls = '0;
      best_cnt = '0;
      for (int unsigned c = 0; c < NCLS; c++) begin
         if (class_cnt[c] > best_cnt) begin
            best_cls = TYPE_W'(c);
            best_cnt = class_cnt[c];
         end
      end
   end

   always_comb begin
      state_n = state;
      emit    = 1'b0;
      flush   = clear;
      case (state)
         COLLECT: if (accept && last_sample) state_n = VOTE;
         VOTE:    if (last_idx) state_n = DECIDE;
         DECIDE: begin
`ifdef KNN_TIE_NEAREST_EN
            state_n = RESOLVE;
`else
            emit    = 1'b1;
            flush   = 1'b1;
            state_n = COLLECT;
`endif
         end
         RESOLVE: begin
`ifdef KNN_TIE_NEAREST_EN
            if (last_idx) begin
               emit    = 1'b1;
               flush   = 1'b1;
               state_n = COLLECT;
            end
`else
            state_n = COLLECT;
`endif
         end
      endcase
      if (clear) begin
         state_n = COLLECT;
         emit    = 1'b0;
      end
   end

`ifdef KNN_TIE_NEAREST_EN
   logic [CW-1:0]     max_cnt;
   logic              tie_found;
   logic [TYPE_W-1:0] tie_cls;
   logic              hit;

   always_comb begin
      hit       = ent_valid[idx] && (class_cnt[ent_cls[idx]] == max_cnt);
      res_cls   = tie_found ? tie_cls : ent_cls[idx];
      res_votes = max_cnt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         max_cnt   <= '0;
         tie_found <= 1'b0;
         tie_cls   <= '0;
      end else if (state == DECIDE) begin
         max_cnt   <= best_cnt;
         tie_found <= 1'b0;
      end else if (state == RESOLVE && hit && !tie_found) begin
         tie_found <= 1'b1;
         tie_cls   <= ent_cls[idx];
      end
   end
`else
   always_comb begin
      res_cls   = best_cls;
      res_votes = best_cnt;
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= COLLECT;
         idx              <= '0;
         scnt             <= '0;
         class_cnt        <= '0;
         overflow         <= 1'b0;
         result_valid     <= 1'b0;
         result_class     <= '0;
         result_votes     <= '0;
         nearest_distance <= '0;
      end else begin
         state        <= state_n;
         result_valid <= emit;
         if (clear) begin
            idx      <= '0;
            scnt     <= '0;
            overflow <= 1'b0;
         end else begin
            if (dist_valid && busy) overflow <= 1'b1;
            if (accept) scnt <= last_sample ? '0 : scnt + 1'b1;
            // counters stay zero while collecting, so VOTE always starts clean
            if (state == COLLECT) begin
               idx       <= '0;
               class_cnt <= '0;
            end else if (state == VOTE || state == RESOLVE) begin
               idx <= last_idx ? '0 : idx + 1'b1;
               if (state == VOTE && ent_valid[idx]) begin
                  class_cnt[ent_cls[idx]] <= class_cnt[ent_cls[idx]] + 1'b1;
               end
            end
         end
         if (emit) begin
            result_class     <= res_cls;
            result_votes     <= res_votes;
            nearest_distance <= ent_dist[0];
         end
      end
   end

endmodule

// File: tb/tb_knn_vote_selector.sv
// Directed bench for knn_vote_selector: a K=3/6-sample instance and a K=5/2-sample instance.
module tb_knn_vote_selector;

`ifdef KNN_TIE_NEAREST_EN
   localparam int LAT0 = 7;
   localparam int LAT1 = 11;
   localparam int T2_CLS = 3;
   localparam int T6_CLS = 2;
`else
   localparam int LAT0 = 4;
   localparam int LAT1 = 6;
   localparam int T2_CLS = 0;
   localparam int T6_CLS = 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        clear0 = 1'b0, dv0 = 1'b0;
   logic [63:0] dist0 = '0;
   logic [1:0]  typ0 = '0;
   logic        busy0, rv0, ov0;
   logic [1:0]  cls0, votes0;
   logic [63:0] near0;

   logic        clear1 = 1'b0, dv1 = 1'b0;
   logic [63:0] dist1 = '0;
   logic [1:0]  typ1 = '0;
   logic        busy1, rv1, ov1;
   logic [1:0]  cls1;
   logic [2:0]  votes1;
   logic [63:0] near1;

   knn_vote_selector #(.W(32), .TYPE_W(2), .K(3), .NUM_SAMPLES(6)) dut0 (
      .clk(clk), .rst(rst), .clear(clear0), .dist_valid(dv0), .distance(dist0),
      .data_type(typ0), .busy(busy0), .result_valid(rv0), .result_class(cls0),
      .result_votes(votes0), .nearest_distance(near0), .overflow(ov0)
   );

   knn_vote_selector #(.W(32), .TYPE_W(2), .K(5), .NUM_SAMPLES(2)) dut1 (
      .clk(clk), .rst(rst), .clear(clear1), .dist_valid(dv1), .distance(dist1),
      .data_type(typ1), .busy(busy1), .result_valid(rv1), .result_class(cls1),
      .result_votes(votes1), .nearest_distance(near1), .overflow(ov1)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // inputs change on the falling edge; the call returns on the next falling edge
   task automatic strobe0(input logic [63:0] d, input logic [1:0] t);
      dv0 = 1'b1; dist0 = d; typ0 = t;
      @(negedge clk);
      dv0 = 1'b0;
   endtask

   task automatic strobe1(input logic [63:0] d, input logic [1:0] t);
      dv1 = 1'b1; dist1 = d; typ1 = t;
      @(negedge clk);
      dv1 = 1'b0;
   endtask

   task automatic run_t1;
      logic [63:0] d [6];
      logic [1:0]  t [6];
      d = '{64'd50, 64'd10, 64'd30, 64'd70, 64'd20, 64'd90};
      t = '{2'd1, 2'd2, 2'd2, 2'd0, 2'd1, 2'd3};
      for (int i = 0; i < 6; i++) strobe0(d[i], t[i]);
   endtask

   task automatic result0(input string tag, input int exp_lat, input int exp_cls,
                          input int exp_votes, input int exp_near);
      int lat;
      lat = -1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (rv0) begin
            lat = n;
            break;
         end
      end
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_cls"}, cls0, exp_cls);
      check({tag, "_votes"}, votes0, exp_votes);
      check({tag, "_near"}, near0, exp_near);
      @(negedge clk);
      check({tag, "_pulse"}, rv0, 0);
      check({tag, "_busy"}, busy0, 0);
   endtask

   initial begin
      int rv_seen;
      #3;
      check("rst_busy", busy0, 0);
      check("rst_rv", rv0, 0);
      check("rst_cls", cls0, 0);
      check("rst_votes", votes0, 0);
      check("rst_near", near0, 0);
      check("rst_ov", ov0, 0);
      check("rst_rv1", rv1, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // 1: basic sort and majority
      run_t1();
      result0("t1", LAT0, 2, 2, 10);
      check("t1_ov", ov0, 0);

      // 2: three-way tie, one vote each
      strobe0(10, 3); strobe0(20, 1); strobe0(30, 0);
      strobe0(100, 2); strobe0(110, 2); strobe0(120, 2);
      result0("t2", LAT0, T2_CLS, 1, 10);

      // 3: equal distances keep arrival order, fourth equal is dropped
      strobe0(40, 1); strobe0(40, 2); strobe0(40, 3);
      strobe0(40, 0); strobe0(50, 0); strobe0(60, 0);
      result0("t3", LAT0, 1, 1, 40);

      // 4: strobe while busy sets overflow only
      run_t1();
      check("t4_busy", busy0, 1);
      dv0 = 1'b1; dist0 = 5; typ0 = 3;
      @(negedge clk);
      dv0 = 1'b0;
      check("t4_ov_set", ov0, 1);
      result0("t4", LAT0 - 1, 2, 2, 10);
      check("t4_ov_hold", ov0, 1);
      clear0 = 1'b1;
      @(negedge clk);
      clear0 = 1'b0;
      check("t4_ov_clr", ov0, 0);
      check("t4_cls_kept", cls0, 2);

      // clear mid-collect restarts the sample count
      strobe0(1, 3); strobe0(2, 3); strobe0(3, 3);
      clear0 = 1'b1;
      @(negedge clk);
      clear0 = 1'b0;
      run_t1();
      result0("t4c", LAT0, 2, 2, 10);

      // clear during VOTE aborts with no result
      run_t1();
      clear0 = 1'b1;
      @(negedge clk);
      clear0 = 1'b0;
      rv_seen = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (rv0) rv_seen++;
      end
      check("t4_abort_rv", rv_seen, 0);
      check("t4_abort_busy", busy0, 0);

      // 5: asynchronous reset during VOTE
      run_t1();
      @(negedge clk);
      #1 rst = 1'b0;
      #2;
      check("t5_busy", busy0, 0);
      check("t5_cls", cls0, 0);
      check("t5_votes", votes0, 0);
      check("t5_near", near0, 0);
      check("t5_rv", rv0, 0);
      #3 rst = 1'b1;
      rv_seen = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (rv0) rv_seen++;
      end
      check("t5_no_rv", rv_seen, 0);
      run_t1();
      result0("t5", LAT0, 2, 2, 10);

      // 6: fewer samples than K
      begin
         int lat;
         strobe1(60, 2);
         strobe1(60, 1);
         lat = -1;
         for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (rv1) begin
               lat = n;
               break;
            end
         end
         check("t6_lat", lat, LAT1);
         check("t6_cls", cls1, T6_CLS);
         check("t6_votes", votes1, 1);
         check("t6_near", near1, 60);
         @(negedge clk);
         check("t6_pulse", rv1, 0);
         check("t6_ov", ov1, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
